// File: rtl/mp_adder_pkg.sv
// Shared constants and state encoding for the multi-precision add sequencer.
package mp_adder_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, minimum 1 bit so a two-word index still has a real register
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mp_adder_seq_adder32.sv
// Adder32: 32-bit carry-lookahead adder, 4-bit groups with group-level lookahead.
module Adder32 (
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iC,
  output logic [31:0] oS,
  output logic        oC,
  output logic        oG,
  output logic        oP
);

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;
  logic [7:0]  w_gg;
  logic [7:0]  w_pg;
  logic [8:0]  w_cg;
  logic        w_gall;

  assign w_g = iA & iB;
  assign w_p = iA ^ iB;

  always_comb begin
    w_gg   = '0;
    w_pg   = '0;
    w_cg   = '0;
    w_c    = '0;
    w_gall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_pg[k] = w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k];
    end
    w_cg[0] = iC;
    for (int k = 0; k < 8; k++) begin
      w_cg[k+1] = w_gg[k] | (w_pg[k] & w_cg[k]);
      w_gall    = w_gg[k] | (w_pg[k] & w_gall);
    end
    // In-group carries expanded from the group carry-in
    for (int k = 0; k < 8; k++) begin
      w_c[4*k]   = w_cg[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_cg[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_cg[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_cg[k]);
    end
  end

  assign oS = w_p ^ w_c;
  assign oC = w_cg[8];
  assign oG = w_gall;
  assign oP = &w_p;

endmodule

// File: rtl/mp_adder_seq.sv
// mp_adder_seq: WIDTH-bit add sequenced one 32-bit word per cycle through Adder32.
// Define MP_ADDER_SUB_EN to enable subtraction via iSub.
module mp_adder_seq
  import mp_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 128
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  input  logic             iSub,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oS,
  output logic             oC,
  output logic             oZero,
  output logic             oBusy
);

  localparam int unsigned WORDS = WIDTH / WORD_W;
  localparam int unsigned IW    = clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  if ((WIDTH % WORD_W) != 0 || WIDTH < 64) begin : g_bad_width
    $error("mp_adder_seq: WIDTH must be a multiple of 32 and >= 64");
  end

  state_e                      r_state;
  logic [WORDS-1:0][WORD_W-1:0] r_a;
  logic [WORDS-1:0][WORD_W-1:0] r_b;
  logic [WORDS-1:0][WORD_W-1:0] r_s;
  logic [IW-1:0]               r_idx;
  logic                        r_fin;
  logic                        r_carry;
  logic                        r_c;
  logic                        r_zero;
  logic                        r_valid;
  logic                        r_ready;
  logic                        r_busy;

  logic [WIDTH-1:0]  w_b_in;
  logic              w_c_in;
  logic [WORD_W-1:0] w_sum;
  logic              w_cout;
  logic              w_g_unused;
  logic              w_p_unused;

`ifdef MP_ADDER_SUB_EN
  // Subtract as A + ~B + 1; carry-out of 1 means no borrow
  assign w_b_in = iSub ? ~iB : iB;
  assign w_c_in = iSub | iC;
`else
  logic w_sub_unused;
  assign w_sub_unused = iSub;
  assign w_b_in = iB;
  assign w_c_in = iC;
`endif

  Adder32 u_adder32 (
    .iA (r_a[r_idx]),
    .iB (r_b[r_idx]),
    .iC (r_carry),
    .oS (w_sum),
    .oC (w_cout),
    .oG (w_g_unused),
    .oP (w_p_unused)
  );

  // Sequencer: one word per RUN cycle, then one finalize cycle for flags
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_fin   <= 1'b0;
      r_carry <= 1'b0;
      r_c     <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (iValid && r_ready) begin
            r_a     <= iA;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_idx   <= '0;
            r_fin   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_fin) begin
            r_c     <= r_carry;
            r_zero  <= (r_s == '0);
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_s[r_idx] <= w_sum;
            r_carry    <= w_cout;
            if (r_idx == LAST) r_fin <= 1'b1;
            else               r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (iReady) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oReady = r_ready;
  assign oValid = r_valid;
  assign oS     = r_s;
  assign oC     = r_c;
  assign oZero  = r_zero;
  assign oBusy  = r_busy;

endmodule

// File: tb/tb_mp_adder_seq.sv
// Self-checking bench for mp_adder_seq (WIDTH=128): directed table, corner sequences, random ops.
module tb_mp_adder_seq;

  localparam int unsigned W     = 128;
  localparam int unsigned WX    = W + 1;
  localparam int unsigned WORDS = W / 32;
  localparam int unsigned NV    = 11;

  logic         clk = 1'b0;
  logic         iRstN;
  logic         iValid;
  logic         oReady;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic         iC;
  logic         iSub;
  logic         oValid;
  logic         iReady;
  logic [W-1:0] oS;
  logic         oC;
  logic         oZero;
  logic         oBusy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mp_adder_seq #(.WIDTH(W)) dut (
    .iClk   (clk),
    .iRstN  (iRstN),
    .iValid (iValid),
    .oReady (oReady),
    .iA     (iA),
    .iB     (iB),
    .iC     (iC),
    .iSub   (iSub),
    .oValid (oValid),
    .iReady (iReady),
    .oS     (oS),
    .oC     (oC),
    .oZero  (oZero),
    .oBusy  (oBusy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         z;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [WX-1:0] act, input logic [WX-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one op at a negedge; returns sampled result and edges from acceptance to oValid
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sub, output logic [W-1:0] s, output logic co,
                        output logic z, output int lat, output logic ok);
    int waitc;
    iA = a; iB = b; iC = c; iSub = sub; iValid = 1'b1;
    waitc = 0;
    s = '0; co = 1'b0; z = 1'b0; lat = 0; ok = 1'b0;
    while (!oReady && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (oReady) begin
      @(negedge clk);
      iValid = 1'b0;
      iA = ~a; iB = ~b; iC = ~c; iSub = ~sub;
      while (!oValid && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      s = oS; co = oC; z = oZero; ok = oValid;
    end else begin
      iValid = 1'b0;
    end
  endtask

  task automatic release_result();
    iReady = 1'b1;
    @(negedge clk);
    iReady = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] s;
    logic         co;
    logic         z;
    logic         ok;
    int           lat;
    logic [W:0]   ref_sum;

    vecs[0] = '{{W{1'b1}}, 128'h1, 1'b0, 1'b0, 128'h0, 1'b1, 1'b1};
    vecs[1] = '{128'hFFFFFFFF, 128'h1, 1'b1, 1'b0, 128'h1_00000001, 1'b0, 1'b0};
    vecs[2] = '{128'h0, 128'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b1};
    vecs[3] = '{128'h0, 128'h0, 1'b1, 1'b0, 128'h1, 1'b0, 1'b0};
    vecs[4] = '{{W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0, {W{1'b1}}, 1'b1, 1'b0};
    vecs[5] = '{128'h80000000_00000000_00000000_00000000, 128'h80000000_00000000_00000000_00000000,
                1'b0, 1'b0, 128'h0, 1'b1, 1'b1};
    vecs[6] = '{128'h00000001_00000002_00000003_00000004, 128'h10000000_20000000_30000000_40000000,
                1'b0, 1'b0, 128'h10000001_20000002_30000003_40000004, 1'b0, 1'b0};
    vecs[7] = '{128'h5, 128'h7, 1'b1, 1'b0, 128'hD, 1'b0, 1'b0};
`ifdef MP_ADDER_SUB_EN
    vecs[8]  = '{128'h5, 128'h7, 1'b0, 1'b1, {{(W-4){1'b1}}, 4'hE}, 1'b0, 1'b0};
    vecs[9]  = '{128'h7, 128'h7, 1'b0, 1'b1, 128'h0, 1'b1, 1'b1};
    vecs[10] = '{128'h7, 128'h7, 1'b1, 1'b1, 128'h0, 1'b1, 1'b1};
`else
    vecs[8]  = '{128'h5, 128'h7, 1'b0, 1'b1, 128'hC, 1'b0, 1'b0};
    vecs[9]  = '{128'h7, 128'h7, 1'b0, 1'b1, 128'hE, 1'b0, 1'b0};
    vecs[10] = '{128'h7, 128'h7, 1'b1, 1'b1, 128'hF, 1'b0, 1'b0};
`endif

    iRstN = 1'b0; iValid = 1'b0; iReady = 1'b0;
    iA = '0; iB = '0; iC = 1'b0; iSub = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_valid", WX'(oValid), WX'(0));
    chk("rst_ready", WX'(oReady), WX'(0));
    chk("rst_s", {1'b0, oS}, WX'(0));
    chk("rst_busy", WX'(oBusy), WX'(0));
    iRstN = 1'b1;
    @(negedge clk);
    chk("rel_ready", WX'(oReady), WX'(1));

    for (int i = 0; i < int'(NV); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub, s, co, z, lat, ok);
      chk($sformatf("v%0d_ok", i), WX'(ok), WX'(1));
      chk($sformatf("v%0d_lat", i), WX'(lat), WX'(WORDS + 1));
      chk($sformatf("v%0d_s", i), {1'b0, s}, {1'b0, vecs[i].s});
      chk($sformatf("v%0d_c", i), WX'(co), WX'(vecs[i].co));
      chk($sformatf("v%0d_z", i), WX'(z), WX'(vecs[i].z));
      chk($sformatf("v%0d_rdy_done", i), WX'(oReady), WX'(0));
      release_result();
      chk($sformatf("v%0d_vld_drop", i), WX'({oValid, oReady}), WX'(2'b01));
    end

    // Reset while RUN discards the partial result
    iA = {W{1'b1}}; iB = '0; iC = 1'b0; iSub = 1'b0; iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", WX'(oBusy), WX'(1));
    chk("mid_partial", WX'(oS[31:0]), WX'(32'hFFFFFFFF));
    iRstN = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_valid", WX'(oValid), WX'(0));
    chk("abort_s", {1'b0, oS}, WX'(0));
    chk("abort_c", WX'(oC), WX'(0));
    chk("abort_busy", WX'(oBusy), WX'(0));
    iRstN = 1'b1;
    @(negedge clk);
    chk("abort_rel_ready", WX'(oReady), WX'(1));

    // Backpressure: result held while a new request waits
    run_op(128'h00000000_FFFFFFFF_00000000_FFFFFFFF, 128'h1, 1'b0, 1'b0, s, co, z, lat, ok);
    chk("bp_first", {1'b0, s}, WX'(128'h00000000_FFFFFFFF_00000001_00000000));
    iA = 128'h2; iB = 128'h3; iC = 1'b1; iSub = 1'b0; iValid = 1'b1; iReady = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_s%0d", k), {1'b0, oS}, WX'(128'h00000000_FFFFFFFF_00000001_00000000));
      chk($sformatf("bp_hold_hs%0d", k), WX'({oValid, oReady, oBusy}), WX'(3'b101));
    end
    release_result();
    chk("bp_idle", WX'({oValid, oReady}), WX'(2'b01));
    run_op(128'h2, 128'h3, 1'b1, 1'b0, s, co, z, lat, ok);
    chk("bp_second_lat", WX'(lat), WX'(WORDS + 1));
    chk("bp_second_s", {co, s}, WX'(6));
    release_result();

    // Random ops against an A+B+C reference with random handshake gaps
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (n % 7 == 0) rb = ~ra;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
`ifdef MP_ADDER_SUB_EN
      if (rs) ref_sum = {1'b0, ra} + {1'b0, ~rb} + WX'(1);
      else    ref_sum = {1'b0, ra} + {1'b0, rb} + WX'(rc);
`else
      ref_sum = {1'b0, ra} + {1'b0, rb} + WX'(rc);
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, rc, rs, s, co, z, lat, ok);
      chk($sformatf("rnd%0d", n), {co, s}, ref_sum);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
